// File: rtl/bundle_ctrl.sv
// Majority bundler: folds a stream of hypervectors into saturating signed
// per-dimension counters, then streams out the sign of every counter.
module bundle_ctrl #(
    parameter int DIM_W     = 32,
    parameter int NUM_WORDS = 32,
    parameter int CNT_W     = 8,
    parameter int NV_W      = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [NV_W-1:0]  num_vec,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [DIM_W-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [DIM_W-1:0] out_data,
    output logic             out_last,
    output logic             busy,
    output logic             done
);

    localparam int IDX_W = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
    localparam logic [IDX_W-1:0]      LAST_IDX = IDX_W'(NUM_WORDS - 1);
    localparam logic signed [CNT_W:0] CNT_MAX  = (CNT_W+1)'((1 << (CNT_W-1)) - 1);
    localparam logic signed [CNT_W:0] CNT_MIN  = (CNT_W+1)'(-(1 << (CNT_W-1)));
    // Kept one bit wider than the counter so +1/-1 never sign-extends wrongly
    localparam logic signed [CNT_W:0] INC_POS  = (CNT_W+1)'(1);
    localparam logic signed [CNT_W:0] INC_NEG  = (CNT_W+1)'(-1);

    typedef enum logic [1:0] {IDLE, ACCUM, EMIT} state_t;

    state_t           state_reg;
    logic [IDX_W-1:0] word_idx_reg;
    logic [NV_W-1:0]  vec_cnt_reg;
    logic [NV_W-1:0]  num_vec_reg;
    logic             done_reg;

    logic             accept;
    logic             clear;
    logic [NV_W-1:0]  vec_cnt_next;
    logic [DIM_W-1:0] sign_words [NUM_WORDS];

    assign accept       = (state_reg == ACCUM) && in_valid;
    assign clear        = (state_reg == IDLE) && start;
    assign vec_cnt_next = vec_cnt_reg + NV_W'(1);

    genvar gw, gi;
    generate
        for (gw = 0; gw < NUM_WORDS; gw++) begin : g_word
            for (gi = 0; gi < DIM_W; gi++) begin : g_lane
                logic signed [CNT_W-1:0] cnt_reg;
                logic signed [CNT_W:0]   sum_next;
                logic signed [CNT_W-1:0] cnt_next;

                always_comb begin
                    sum_next = $signed({cnt_reg[CNT_W-1], cnt_reg})
                             + (in_data[gi] ? INC_NEG : INC_POS);
                    if (sum_next > CNT_MAX)
                        cnt_next = CNT_MAX[CNT_W-1:0];
                    else if (sum_next < CNT_MIN)
                        cnt_next = CNT_MIN[CNT_W-1:0];
                    else
                        cnt_next = sum_next[CNT_W-1:0];
                end

                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n)
                        cnt_reg <= '0;
                    else if (clear)
                        cnt_reg <= '0;
                    else if (accept && (word_idx_reg == IDX_W'(gw)))
                        cnt_reg <= cnt_next;
                end

                // Negative counter votes 1; ties fall to 0
                assign sign_words[gw][gi] = cnt_reg[CNT_W-1];
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            word_idx_reg <= '0;
            vec_cnt_reg  <= '0;
            num_vec_reg  <= '0;
            done_reg     <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        num_vec_reg  <= num_vec;
                        word_idx_reg <= '0;
                        vec_cnt_reg  <= '0;
                        state_reg    <= (num_vec == '0) ? EMIT : ACCUM;
                    end
                end
                ACCUM: begin
                    if (in_valid) begin
                        if (word_idx_reg == LAST_IDX) begin
                            word_idx_reg <= '0;
                            vec_cnt_reg  <= vec_cnt_next;
                            if (vec_cnt_next == num_vec_reg)
                                state_reg <= EMIT;
                        end else begin
                            word_idx_reg <= word_idx_reg + IDX_W'(1);
                        end
                    end
                end
                EMIT: begin
                    if (out_ready) begin
                        if (word_idx_reg == LAST_IDX) begin
                            word_idx_reg <= '0;
                            state_reg    <= IDLE;
                            done_reg     <= 1'b1;
                        end else begin
                            word_idx_reg <= word_idx_reg + IDX_W'(1);
                        end
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state_reg == ACCUM);
    assign out_valid = (state_reg == EMIT);
    assign out_last  = (state_reg == EMIT) && (word_idx_reg == LAST_IDX);
    assign out_data  = sign_words[word_idx_reg];
    assign busy      = (state_reg != IDLE);
    assign done      = done_reg;

endmodule

// File: tb/tb_bundle_ctrl.sv
// Scoreboard bench for bundle_ctrl: a saturating counter model predicts each
// bundled word as stimulus is driven; emitted words are popped and compared.
module tb_bundle_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [15:0] num_vec;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_data;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  out_data;
    logic        out_last;
    logic        busy;
    logic        done;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [3:0]  stim_q [$];
    logic [4:0]  exp_q  [$];

    bundle_ctrl #(.DIM_W(4), .NUM_WORDS(2), .CNT_W(4), .NV_W(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .num_vec   (num_vec),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            $display("ok   %s: %0h", tag, got);
        end
    endtask

    // nv vectors from stim_q; gap idles in_valid before odd beats; stall holds
    // out_ready low on the first word; poke pulses start while busy.
    task automatic run_job(input int nv, input bit gap, input int stall, input bit poke);
        int         m [2][4];
        int         t;
        logic [3:0] bits;
        logic [3:0] held_d;
        logic       held_l;
        logic [4:0] e;
        for (int w = 0; w < 2; w++)
            for (int b = 0; b < 4; b++)
                m[w][b] = 0;

        @(negedge clk);
        start   = 1'b1;
        num_vec = nv[15:0];
        @(negedge clk);
        start   = 1'b0;
        num_vec = 16'd0;
        check_val("busy_after_start", busy, 1);

        for (int k = 0; k < stim_q.size(); k++) begin
            if (gap && (k % 2 == 1)) begin
                in_valid = 1'b0;
                in_data  = 4'hA;
                start    = poke;
                @(negedge clk);
                start    = 1'b0;
            end
            in_valid = 1'b1;
            in_data  = stim_q[k];
            t = 0;
            while (!in_ready && t < 20) begin
                @(negedge clk);
                t++;
            end
            check_val($sformatf("in_ready_beat%0d", k), in_ready, 1);
            for (int b = 0; b < 4; b++) begin
                m[k % 2][b] += stim_q[k][b] ? -1 : 1;
                if (m[k % 2][b] > 7)  m[k % 2][b] = 7;
                if (m[k % 2][b] < -8) m[k % 2][b] = -8;
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        stim_q.delete();

        for (int w = 0; w < 2; w++) begin
            for (int b = 0; b < 4; b++)
                bits[b] = (m[w][b] < 0);
            e = {(w == 1), bits};
            exp_q.push_back(e);
        end

        for (int w = 0; w < 2; w++) begin
            t = 0;
            while (!out_valid && t < 20) begin
                @(negedge clk);
                t++;
            end
            check_val("out_valid", out_valid, 1);
            check_val("in_ready_emit", in_ready, 0);
            if (w == 0 && stall > 0) begin
                held_d    = out_data;
                held_l    = out_last;
                out_ready = 1'b0;
                for (int s = 0; s < stall; s++) begin
                    start   = poke && (s == 0);
                    num_vec = 16'd5;
                    @(negedge clk);
                    start   = 1'b0;
                    num_vec = 16'd0;
                    check_val("stall_data", out_data, held_d);
                    check_val("stall_last", out_last, held_l);
                end
                check_val("stall_valid", out_valid, 1);
            end
            out_ready = 1'b1;
            e = exp_q.pop_front();
            check_val($sformatf("word%0d", w), {out_last, out_data}, e);
            check_val("done_early", done, 0);
            @(negedge clk);
            out_ready = 1'b0;
        end
        check_val("done", done, 1);
        check_val("busy_end", busy, 0);
        check_val("out_valid_end", out_valid, 0);
        @(negedge clk);
        check_val("done_pulse", done, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n     = 1'b0;
        start     = 1'b0;
        num_vec   = 16'd0;
        in_valid  = 1'b0;
        in_data   = 4'h0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        check_val("rst_in_ready", in_ready, 0);
        check_val("rst_out_valid", out_valid, 0);
        check_val("rst_out_last", out_last, 0);
        check_val("rst_busy", busy, 0);
        check_val("rst_done", done, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // mixed vectors
        stim_q = '{4'b0000, 4'b1111, 4'b0011, 4'b1111, 4'b0001, 4'b0000};
        run_job(3, 1'b0, 0, 1'b0);

        // saturation low then high
        for (int k = 0; k < 20; k++) stim_q.push_back(4'b1111);
        run_job(10, 1'b0, 0, 1'b0);
        for (int k = 0; k < 20; k++) stim_q.push_back(4'b0000);
        run_job(10, 1'b0, 0, 1'b0);

        // ties resolve to 0
        stim_q = '{4'b1010, 4'b0000, 4'b0101, 4'b1111};
        run_job(2, 1'b0, 0, 1'b0);

        // backpressure with start pokes while busy
        stim_q = '{4'b0000, 4'b1111, 4'b0011, 4'b1111, 4'b0001, 4'b0000};
        run_job(3, 1'b1, 5, 1'b1);

        // zero vectors straight to emit
        run_job(0, 1'b0, 2, 1'b1);

        // abort mid-accumulate
        @(negedge clk);
        start   = 1'b1;
        num_vec = 16'd3;
        @(negedge clk);
        start    = 1'b0;
        in_valid = 1'b1;
        in_data  = 4'b1111;
        repeat (3) @(negedge clk);
        check_val("pre_abort_ready", in_ready, 1);
        rst_n = 1'b0;
        #1;
        check_val("abort_in_ready", in_ready, 0);
        check_val("abort_busy", busy, 0);
        check_val("abort_out_valid", out_valid, 0);
        check_val("abort_done", done, 0);
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_val("post_abort_busy", busy, 0);
        stim_q = '{4'b1100, 4'b0011};
        run_job(1, 1'b0, 0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
